// File: rtl/genius_pkg.sv
// Shared definitions for the Genius memory-game datapath.
// Holds the sub-FSM state encodings, the symbol width, the LFSR taps and
// two small helpers: one-hot symbol decode and a single LFSR step.
package genius_pkg;

  localparam int          SYM_W     = 2;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    P_IDLE,
    P_ON,
    P_OFF,
    P_DONE
  } play_state_e;

  typedef enum logic [1:0] {
    U_IDLE,
    U_WAIT,
    U_DONE
  } user_state_e;

  function automatic logic [3:0] onehot4(input logic [SYM_W-1:0] sym);
    onehot4 = 4'b0001 << sym;
  endfunction

  // Galois form: shift right, fold the taps in when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/genius_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   load, load_val load takes priority over step
//   step           advance one position
//   q              low OUT_W bits of the register (symbol users need only 2)
module lfsr16
  import genius_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'h0000,
  parameter int          OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [15:0]      load_val,
  input  logic             step,
  output logic [OUT_W-1:0] q
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q[OUT_W-1:0];

endmodule

// File: rtl/genius_datapath.sv
// Genius memory-game datapath: answers the game controller's strobes,
// plays back the symbol sequence, checks the player's presses and reports
// status flags.
// Build option: FIXED_SEED_EN - when defined, E1 loads the constant SEED
// and no free-running LFSR is built; otherwise the seed is sampled from a
// free-running LFSR (reset value 16'h0001).
// Ports:
//   CLOCK, reset         clock, asynchronous active-low reset
//   R1                   new game (level, clears rounds/win/seed/FSMs)
//   R2                   next round (rising edge)
//   E1                   seed latch (rising edge)
//   E2, E3, E4           user-play, FPGA-play, check enables (level)
//   SEL                  LED source: 0 playback, 1 synchronized keys
//   key[3:0]             raw asynchronous push-buttons
//   end_FPGA, end_User,  status flags back to the controller
//   end_time, win, match
//   leds[3:0]            registered one-hot display
//   rnd                  current round, 1-based
//
// Playback FSM
//   state  | meaning
//   P_IDLE | waiting for E3 rising
//   P_ON   | symbol idx lit for SHOW_CYC cycles
//   P_OFF  | dark gap for GAP_CYC cycles, then next symbol or done
//   P_DONE | rnd symbols shown, end_FPGA held until E3 falls
//
// User FSM
//   state  | meaning
//   U_IDLE | waiting for E2 rising
//   U_WAIT | taking presses, reply timer running
//   U_DONE | all presses taken, wrong press, or timeout
module genius_datapath
  import genius_pkg::*;
#(
  parameter int          N_ROUNDS    = 16,
  parameter int          SHOW_CYC    = 25_000_000,
  parameter int          GAP_CYC     = 12_500_000,
  parameter int          TIMEOUT_CYC = 250_000_000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                             CLOCK,
  input  logic                             reset,
  input  logic                             R1,
  input  logic                             R2,
  input  logic                             E1,
  input  logic                             E2,
  input  logic                             E3,
  input  logic                             E4,
  input  logic                             SEL,
  input  logic [3:0]                       key,
  output logic                             end_FPGA,
  output logic                             end_User,
  output logic                             end_time,
  output logic                             win,
  output logic                             match,
  output logic [3:0]                       leds,
  output logic [$clog2(N_ROUNDS+1)-1:0]    rnd
);

  localparam int RND_W = $clog2(N_ROUNDS + 1);
  localparam int PC_W  = $clog2(SHOW_CYC + GAP_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PC_W-1:0]  SHOW_LD = PC_W'(SHOW_CYC - 1);
  localparam logic [PC_W-1:0]  GAP_LD  = PC_W'(GAP_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LD   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RND_W-1:0] RND_ONE = RND_W'(1);
  localparam logic [RND_W-1:0] RND_MAX = RND_W'(N_ROUNDS);

  // ---------------------------------------------------------------
  // Input conditioning: strobe edge history and key synchronizer
  // ---------------------------------------------------------------
  logic       r2_q, e1_q, e2_q, e3_q;
  logic [3:0] key_s1_q, key_s2_q, key_prev_q;
  logic [3:0] press_vec;
  logic       press;

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      r2_q       <= 1'b0;
      e1_q       <= 1'b0;
      e2_q       <= 1'b0;
      e3_q       <= 1'b0;
      key_s1_q   <= 4'b0000;
      key_s2_q   <= 4'b0000;
      key_prev_q <= 4'b0000;
    end else begin
      r2_q       <= R2;
      e1_q       <= E1;
      e2_q       <= E2;
      e3_q       <= E3;
      key_s1_q   <= key;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

  assign press_vec = key_s2_q & ~key_prev_q;
  assign press     = |press_vec;

  // ---------------------------------------------------------------
  // Seed source, round counter, win flag
  // ---------------------------------------------------------------
  logic [15:0]      seed_src;
  logic [15:0]      seed_q;
  logic [RND_W-1:0] rnd_q;
  logic             win_q;

`ifdef FIXED_SEED_EN
  assign seed_src = SEED;
`else
  lfsr16 #(
    .RESET_VAL (16'h0001),
    .OUT_W     (16)
  ) u_free_lfsr (
    .clk      (CLOCK),
    .rst_n    (reset),
    .load     (1'b0),
    .load_val (16'h0000),
    .step     (1'b1),
    .q        (seed_src)
  );
`endif

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      rnd_q  <= RND_ONE;
      win_q  <= 1'b0;
      seed_q <= 16'h0000;
    end else if (R1) begin
      rnd_q  <= RND_ONE;
      win_q  <= 1'b0;
      seed_q <= 16'h0000;
    end else begin
      if (R2 && !r2_q) begin
        if (rnd_q < RND_MAX) begin
          rnd_q <= rnd_q + RND_ONE;
        end else begin
          win_q <= 1'b1;
        end
      end
      if (E1 && !e1_q) begin
        seed_q <= seed_src;
      end
    end
  end

  // ---------------------------------------------------------------
  // Playback FSM
  // ---------------------------------------------------------------
  play_state_e      p_q, p_d;
  logic [PC_W-1:0]  p_cnt_q, p_cnt_d;
  logic [RND_W-1:0] idx_q, idx_d;
  logic             play_load, play_step;
  logic [SYM_W-1:0] play_sym;
  logic [3:0]       leds_play;

  lfsr16 #(
    .RESET_VAL (16'h0000),
    .OUT_W     (SYM_W)
  ) u_play_lfsr (
    .clk      (CLOCK),
    .rst_n    (reset),
    .load     (play_load),
    .load_val (seed_q),
    .step     (play_step),
    .q        (play_sym)
  );

  always_comb begin
    p_d       = p_q;
    p_cnt_d   = p_cnt_q;
    idx_d     = idx_q;
    play_load = 1'b0;
    play_step = 1'b0;
    if (R1 || !E3) begin
      p_d = P_IDLE;
    end else begin
      case (p_q)
        P_IDLE: begin
          if (!e3_q) begin
            play_load = 1'b1;
            idx_d     = '0;
            p_cnt_d   = SHOW_LD;
            p_d       = P_ON;
          end
        end
        P_ON: begin
          if (p_cnt_q == '0) begin
            p_cnt_d = GAP_LD;
            p_d     = P_OFF;
          end else begin
            p_cnt_d = p_cnt_q - 1'b1;
          end
        end
        P_OFF: begin
          if (p_cnt_q == '0) begin
            idx_d     = idx_q + RND_ONE;
            play_step = 1'b1;
            if (idx_d == rnd_q) begin
              p_d = P_DONE;
            end else begin
              p_cnt_d = SHOW_LD;
              p_d     = P_ON;
            end
          end else begin
            p_cnt_d = p_cnt_q - 1'b1;
          end
        end
        P_DONE:  p_d = P_DONE;
        default: p_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      p_q     <= P_IDLE;
      p_cnt_q <= '0;
      idx_q   <= '0;
    end else begin
      p_q     <= p_d;
      p_cnt_q <= p_cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Gated by E3 so the display goes dark in the same cycle E3 drops.
  assign leds_play = (p_q == P_ON && E3) ? onehot4(play_sym) : 4'b0000;

  // ---------------------------------------------------------------
  // User FSM
  // ---------------------------------------------------------------
  user_state_e      u_q, u_d;
  logic [TO_W-1:0]  u_cnt_q, u_cnt_d;
  logic [RND_W-1:0] uidx_q, uidx_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             chk_load, chk_step;
  logic [SYM_W-1:0] chk_sym;

  lfsr16 #(
    .RESET_VAL (16'h0000),
    .OUT_W     (SYM_W)
  ) u_chk_lfsr (
    .clk      (CLOCK),
    .rst_n    (reset),
    .load     (chk_load),
    .load_val (seed_q),
    .step     (chk_step),
    .q        (chk_sym)
  );

  always_comb begin
    u_d      = u_q;
    u_cnt_d  = u_cnt_q;
    uidx_d   = uidx_q;
    err_d    = err_q;
    to_d     = to_q;
    chk_load = 1'b0;
    chk_step = 1'b0;
    if (R1) begin
      u_d    = U_IDLE;
      uidx_d = '0;
      err_d  = 1'b0;
      to_d   = 1'b0;
    end else if (!E2) begin
      // uidx and err stay put so E4 can still evaluate match.
      u_d = U_IDLE;
    end else begin
      case (u_q)
        U_IDLE: begin
          if (!e2_q) begin
            chk_load = 1'b1;
            uidx_d   = '0;
            err_d    = 1'b0;
            to_d     = 1'b0;
            u_cnt_d  = TO_LD;
            u_d      = U_WAIT;
          end
        end
        U_WAIT: begin
          // A press is checked before the terminal count, so a press on
          // the last allowed cycle is accepted rather than timing out.
          if (press) begin
            chk_step = 1'b1;
            uidx_d   = uidx_q + RND_ONE;
            u_cnt_d  = TO_LD;
            if (press_vec != onehot4(chk_sym)) begin
              err_d = 1'b1;
            end
            if (err_d || uidx_d == rnd_q) begin
              u_d = U_DONE;
            end
          end else if (u_cnt_q == '0) begin
            to_d = 1'b1;
            u_d  = U_DONE;
          end else begin
            u_cnt_d = u_cnt_q - 1'b1;
          end
        end
        U_DONE:  u_d = U_DONE;
        default: u_d = U_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      u_q     <= U_IDLE;
      u_cnt_q <= '0;
      uidx_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      u_q     <= u_d;
      u_cnt_q <= u_cnt_d;
      uidx_q  <= uidx_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  // ---------------------------------------------------------------
  // LED output register and flag decode
  // ---------------------------------------------------------------
  logic [3:0] leds_q;

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      leds_q <= 4'b0000;
    end else if (R1) begin
      leds_q <= 4'b0000;
    end else begin
      leds_q <= SEL ? key_s2_q : leds_play;
    end
  end

  assign leds     = leds_q;
  assign rnd      = rnd_q;
  assign win      = win_q;
  assign end_FPGA = (p_q == P_DONE) & E3;
  assign end_User = (u_q == U_DONE) & ~to_q & E2;
  assign end_time = (u_q == U_DONE) &  to_q & E2;
  assign match    = E4 & ~err_q & (uidx_q == rnd_q);

endmodule

// File: tb/tb_genius_datapath.sv
module tb_genius_datapath;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TOUT = 20;
  localparam int NR   = 2;

  logic       CLOCK = 1'b0;
  logic       reset;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [3:0] key;
  logic       end_FPGA, end_User, end_time, win, match;
  logic [3:0] leds;
  logic [1:0] rnd;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] leds;
    logic       endf;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] free_m;
  logic [15:0] exp_seed;

  genius_datapath #(
    .N_ROUNDS    (NR),
    .SHOW_CYC    (SHOW),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TOUT),
    .SEED        (16'hACE1)
  ) dut (
    .CLOCK    (CLOCK),
    .reset    (reset),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .SEL      (SEL),
    .key      (key),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .leds     (leds),
    .rnd      (rnd)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [15:0] step16(input logic [15:0] q);
    step16 = {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] exp_oh(input logic [15:0] s, input int k);
    logic [15:0] q;
    q = s;
    for (int i = 0; i < k; i++) q = step16(q);
    exp_oh = 4'b0001 << q[1:0];
  endfunction

  // Reference for the free-running seed source.
  always @(posedge CLOCK or negedge reset) begin
    if (!reset) free_m <= 16'h0001;
    else        free_m <= step16(free_m);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic latch_seed();
`ifdef FIXED_SEED_EN
    exp_seed = 16'hACE1;
`else
    exp_seed = free_m;
`endif
    E1 = 1'b1;
    tick(1);
    E1 = 1'b0;
    tick(1);
  endtask

  task automatic push_play(input int r);
    exp_t e;
    e.leds = 4'b0000; e.endf = 1'b0;
    sb.push_back(e);
    for (int k = 0; k < r; k++) begin
      for (int c = 0; c < SHOW; c++) begin
        e.leds = exp_oh(exp_seed, k); e.endf = 1'b0;
        sb.push_back(e);
      end
      for (int c = 0; c < GAP; c++) begin
        e.leds = 4'b0000;
        e.endf = (k == r - 1) && (c == GAP - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain_play(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      tick(1);
      e = sb.pop_front();
      chk_val({tag, "_leds"}, leds, e.leds);
      chk_val({tag, "_endf"}, end_FPGA, e.endf);
    end
  endtask

  task automatic press(input string tag, input logic [3:0] v, input logic exp_end);
    key = v;
    tick(2);
    chk_val({tag, "_pre"}, end_User, 1'b0);
    tick(1);
    chk_val({tag, "_end"}, end_User, exp_end);
    if (SEL) chk_val({tag, "_echo"}, leds, v);
    key = 4'b0000;
    tick(3);
  endtask

  logic [3:0] wrong_v, multi_v;
  logic [1:0] s0;

  initial begin
    reset = 1'b0;
    {R1, R2, E1, E2, E3, E4, SEL} = '0;
    key = 4'b0000;
    tick(3);
    chk_val("rst_flags", {end_FPGA, end_User, end_time, win, match}, 5'b00000);
    chk_val("rst_leds", leds, 4'b0000);
    chk_val("rst_rnd", rnd, 2'd1);
    reset = 1'b1;
    tick(2);

    R1 = 1'b1; tick(1); R1 = 1'b0; tick(1);
    chk_val("r1_rnd", rnd, 2'd1);
    latch_seed();

    // Playback, round 1
    E3 = 1'b1;
    push_play(1);
    drain_play("play1");
    tick(2);
    chk_val("play1_hold", end_FPGA, 1'b1);
    E3 = 1'b0; #1;
    chk_val("play1_drop", end_FPGA, 1'b0);
    tick(1);

    // Playback, round 2
    R2 = 1'b1; tick(1); R2 = 1'b0; tick(1);
    chk_val("r2_rnd", rnd, 2'd2);
    chk_val("r2_win", win, 1'b0);
    E3 = 1'b1;
    push_play(2);
    drain_play("play2");
    E3 = 1'b0;
    tick(2);

    // Correct replies
    E2 = 1'b1; tick(2);
    press("ok1", exp_oh(exp_seed, 0), 1'b0);
    press("ok2", exp_oh(exp_seed, 1), 1'b1);
    chk_val("ok_time", end_time, 1'b0);
    E2 = 1'b0; #1;
    chk_val("ok_e2low", end_User, 1'b0);
    E4 = 1'b1; #1;
    chk_val("ok_match", match, 1'b1);
    E4 = 1'b0; #1;
    chk_val("ok_match_e4low", match, 1'b0);
    tick(2);

    // Wrong single press, with key echo on the LEDs
    wrong_v = (exp_oh(exp_seed, 0) == 4'b0100) ? 4'b1000 : 4'b0100;
    SEL = 1'b1;
    E2 = 1'b1; tick(2);
    press("wrong", wrong_v, 1'b1);
    chk_val("wrong_time", end_time, 1'b0);
    E4 = 1'b1; #1;
    chk_val("wrong_match", match, 1'b0);
    E4 = 1'b0;
    E2 = 1'b0; SEL = 1'b0;
    tick(2);

    // Multi-bit press containing the right key is still wrong
    s0 = 2'd0;
    for (int i = 0; i < 4; i++) if (exp_oh(exp_seed, 0) == (4'b0001 << i)) s0 = 2'(i);
    multi_v = exp_oh(exp_seed, 0) | (4'b0001 << (s0 + 2'd1));
    E2 = 1'b1; tick(2);
    press("multi", multi_v, 1'b1);
    E4 = 1'b1; #1;
    chk_val("multi_match", match, 1'b0);
    E4 = 1'b0;
    E2 = 1'b0;
    tick(2);

    // Timeout with no press
    E2 = 1'b1;
    tick(TOUT);
    chk_val("to_early", end_time, 1'b0);
    tick(1);
    chk_val("to_fire", end_time, 1'b1);
    chk_val("to_user", end_User, 1'b0);
    E4 = 1'b1; #1;
    chk_val("to_match", match, 1'b0);
    E4 = 1'b0;
    E2 = 1'b0; #1;
    chk_val("to_clear", end_time, 1'b0);
    tick(2);

    // Press landing on the last allowed cycle beats the timeout
    E2 = 1'b1;
    tick(TOUT - 2);
    key = exp_oh(exp_seed, 0);
    tick(3);
    chk_val("edge_time", end_time, 1'b0);
    chk_val("edge_user", end_User, 1'b0);
    key = 4'b0000;
    tick(3);
    press("edge2", exp_oh(exp_seed, 1), 1'b1);
    E2 = 1'b0;
    tick(2);

    // Win at the last round
    R2 = 1'b1; tick(1); R2 = 1'b0; tick(1);
    chk_val("win_set", win, 1'b1);
    chk_val("win_rnd", rnd, 2'd2);
    R2 = 1'b1; tick(1); R2 = 1'b0; tick(1);
    chk_val("win_hold", win, 1'b1);
    R1 = 1'b1; tick(1); R1 = 1'b0; #1;
    chk_val("r1_win", win, 1'b0);
    chk_val("r1_rnd2", rnd, 2'd1);
    tick(1);

    // Asynchronous reset in the middle of a lit symbol
    latch_seed();
    E3 = 1'b1;
    tick(3);
    chk_val("mid_leds", leds, exp_oh(exp_seed, 0));
    reset = 1'b0; #1;
    chk_val("mid_rst_flags", {end_FPGA, end_User, end_time, win, match}, 5'b00000);
    chk_val("mid_rst_leds", leds, 4'b0000);
    chk_val("mid_rst_rnd", rnd, 2'd1);
    E3 = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genius_datapath.md
Name: genius_datapath

Overview:
Datapath that answers the game controller's strobes for the memory ("Genius") game and returns its status flags.
- Consumes R1, R2, E1..E4 and SEL from the controller; drives end_FPGA, end_User, end_time, win and match back to it.
- Generates a pseudo-random symbol sequence, plays the first rnd symbols on the LEDs, captures and checks the player's key presses, and tracks the round count, the reply timeout and the win condition.

Parameters:
N_ROUNDS, 16, rounds to complete for a win.
SHOW_CYC, 25_000_000, cycles each symbol LED is lit.
GAP_CYC, 12_500_000, dark cycles after each symbol.
TIMEOUT_CYC, 250_000_000, idle cycles allowed before end_time.
SEED, 16'hACE1, LFSR seed used when FIXED_SEED_EN is defined.

Ports:
CLOCK  in  1  system clock; all state is posedge.
reset  in  1  asynchronous, active-low reset.
R1  in  1  new-game strobe (level).
R2  in  1  next-round strobe; acts on rising edge only.
E1  in  1  setup; rising edge latches the sequence seed.
E2  in  1  user-play enable (level).
E3  in  1  FPGA-play enable (level).
E4  in  1  check enable (level).
SEL  in  1  LED source select: 0 = playback, 1 = user echo.
key  in  4  raw one-hot push-buttons, asynchronous.
end_FPGA  out  1  playback of rnd symbols complete.
end_User  out  1  rnd presses taken, or a wrong press occurred.
end_time  out  1  reply timeout expired.
win  out  1  N_ROUNDS rounds completed.
match  out  1  all presses correct; valid while E4 is high.
leds  out  4  one-hot symbol display.
rnd  out  $clog2(N_ROUNDS+1)  current round number, 1-based.

Behaviour:
Reset (reset = 0) and R1 = 1:
- all outputs 0; rnd = 1; seed = 0; both sub-FSMs go to idle.
- R1 overrides every E input in the same cycle.

Key input:
- key passes through a 2-flop synchronizer, then rising-edge detection on the vector.
- A press event is a cycle where the edge-detected vector is non-zero.
- A press is correct only if it equals onehot(expected symbol); multi-bit presses are wrong.

Sequence generation:
- Symbol = lfsr[1:0] of a Galois LFSR: right shift, XOR taps 16'hB400 when lsb = 1.
- The seed register is loaded on E1 rising from a free-running LFSR.
- Playback and checking each reload their own LFSR from the seed, so the sequence replays identically every round.

Playback FSM (P_IDLE, P_ON, P_OFF, P_DONE):
- E3 rising: load play LFSR, idx = 0, go to P_ON.
- P_ON: leds_play = onehot(sym) for SHOW_CYC cycles, then P_OFF.
- P_OFF: leds_play = 0 for GAP_CYC cycles; then idx++ and step the LFSR.
  - If idx == rnd: go to P_DONE.
  - Otherwise: go to P_ON.
- P_DONE: end_FPGA = 1 until E3 falls, then P_IDLE.
- E3 low in any state: immediate P_IDLE, leds_play = 0, end_FPGA = 0.

User FSM (U_IDLE, U_WAIT, U_DONE):
- E2 rising: load check LFSR, uidx = 0, err = 0, timer = 0, go to U_WAIT.
- U_WAIT, each cycle: timer++.
  - On a press: compare with the expected symbol; set err on mismatch; uidx++; step the LFSR; timer = 0.
  - If a press and timer == TIMEOUT_CYC-1 occur in the same cycle, the press wins.
- Go to U_DONE when uidx == rnd, or err = 1, or timer reaches TIMEOUT_CYC.
  - end_User = 1 in U_DONE unless the exit was by timeout; then end_time = 1 instead.
- Presses in U_DONE are ignored.
- E2 low: U_IDLE; end_User and end_time clear; err and uidx are held for E4.
- match = E4 & ~err & (uidx == rnd), combinational.

Rounds:
- R2 rising with rnd < N_ROUNDS: rnd++.
- R2 rising with rnd == N_ROUNDS: win = 1 and stays set until R1 or reset; rnd holds.

leds:
- SEL = 0: leds_play.
- SEL = 1: synchronized key, registered.
- Registered output, 1 cycle after the source.

Optional Feature:
FIXED_SEED_EN
- Defined: E1 rising loads seed = SEED and the free-running LFSR is not instantiated; the sequence is deterministic for benches.
- Undefined: seed is taken from the free-running LFSR (reset value 16'h0001) at E1 rising.

Decomposition:
Shared package genius_pkg:
- playback and user state enums;
- SYM_W = 2;
- LFSR_TAPS = 16'hB400;
- onehot4 function.

Sub-module lfsr16 (load, load_val, step, q) is instantiated for play, check and the free-running source.

Test Plan:
All scenarios use FIXED_SEED_EN, SEED = 16'hACE1 (symbols 1,0,0,...), SHOW = 4, GAP = 2, TIMEOUT = 20, N_ROUNDS = 2.
- Reset, R1 pulse, E1 pulse, E3 high at rnd = 1 → leds 0010 for 4 cycles, 0000 for 2, then end_FPGA = 1 until E3 drops.
- R2 pulse (rnd = 2), then E3 → leds 0010 ×4, 0 ×2, 0001 ×4, 0 ×2, then end_FPGA = 1.
- rnd = 2, E2 high, press 0010 then 0001 → end_User = 1 after the 2nd press; E4 → match = 1.
- E2 high, press 0100 → end_User = 1 after sync latency; E4 → match = 0.
- E2 high, no press → end_time = 1 after 20 cycles; end_User = 0.
- R2 at rnd = 2 → win = 1.
- reset low mid-P_ON → all outputs 0 at once, rnd = 1.
